prog_loader: RTL and testbench

Boot-time program loader that sits directly upstream of the CPU's memory bank. It takes a byte stream from a serial receiver over a valid/ready handshake and assembles big-endian 16-bit instruction words. It writes those words to consecutive memory-bank addresses starting at 0, holding the control unit stalled until the image is complete. When it finishes, it hands the memory-bank port back to the control unit and releases the CPU.

---
 rtl/prog_loader_pkg.sv | 22 ++
 rtl/prog_loader_if.sv | 13 +
 rtl/prog_loader.sv | 146 ++++++++++++++
 tb/tb_prog_loader.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// Optional feature macro: PROG_LOADER_CKSUM_EN adds the trailing XOR checksum state.
package prog_loader_pkg;

  localparam int         BYTE_W     = 8;
  localparam logic [7:0] CKSUM_SEED = 8'h00;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_LEN_HI  = 4'd1,
    ST_LEN_LO  = 4'd2,
    ST_DATA_HI = 4'd3,
    ST_DATA_LO = 4'd4,
    ST_WRITE   = 4'd5,
`ifdef PROG_LOADER_CKSUM_EN
    ST_CKSUM   = 4'd6,
`endif
    ST_DONE    = 4'd7,
    ST_ERR     = 4'd8
  } state_e;

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream valid/ready channel from the serial receiver into the loader.
// The receiver side is the master; the loader is the slave.
interface prog_loader_if;
  import prog_loader_pkg::*;

  logic [BYTE_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);

endinterface

// File: rtl/prog_loader.sv
// Boot-time program loader: assembles big-endian 16-bit words from a byte
// stream (LEN_HI, LEN_LO, 2*LEN data bytes) and writes them to the memory
// bank from address 0, keeping the CPU held until the image is complete.
// Optional feature macro: PROG_LOADER_CKSUM_EN appends an XOR checksum byte.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 16,
  parameter int MEM_DEPTH = 256
) (
  input  logic              CLK100MHZ,
  input  logic              rst,
  input  logic              start,
  prog_loader_if.slave      rx,
  output logic              ld_sel,
  output logic [ADDR_W-1:0] ld_addr,
  output logic [DATA_W-1:0] ld_data,
  output logic              ld_write,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [16:0] DEPTH_LIM = 17'(MEM_DEPTH);

  state_e            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic              rxReady;
  logic              accept;
  logic [15:0]       lenFull;
  logic [ADDR_W:0]   countNext;
  logic              canStart;
  logic              lastWord;
`ifdef PROG_LOADER_CKSUM_EN
  logic [7:0]        cksum_q, cksum_d;
`endif

  assign rxReady   = (state_q == ST_LEN_HI) || (state_q == ST_LEN_LO) ||
                     (state_q == ST_DATA_HI) || (state_q == ST_DATA_LO)
`ifdef PROG_LOADER_CKSUM_EN
                     || (state_q == ST_CKSUM)
`endif
                     ;
  assign accept    = rx.rx_valid && rxReady;
  assign lenFull   = {len_q[15:8], rx.rx_data};
  assign countNext = count_q + 1'b1;
  assign canStart  = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR);
  assign lastWord  = (17'(countNext) == {1'b0, len_q});

  assign rx.rx_ready = rxReady;
  assign ld_write    = (state_q == ST_WRITE);
  assign ld_addr     = addr_q;
  assign ld_data     = word_q;
  assign word_count  = count_q;
  assign ld_sel      = (state_q != ST_DONE);
  assign cpu_hold    = (state_q != ST_DONE);
  assign busy        = !canStart;
  assign done        = (state_q == ST_DONE);
  assign err         = (state_q == ST_ERR);

  // Next-state logic: FSM sequencing, length capture, word assembly, counters.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    addr_d  = addr_q;
    count_d = count_q;
    word_d  = word_q;
`ifdef PROG_LOADER_CKSUM_EN
    cksum_d = cksum_q;
    if (accept && (state_q != ST_CKSUM)) cksum_d = cksum_q ^ rx.rx_data;
`endif
    if (canStart && start) begin
      state_d = ST_LEN_HI;
      addr_d  = '0;
      count_d = '0;
`ifdef PROG_LOADER_CKSUM_EN
      cksum_d = CKSUM_SEED;
`endif
    end else begin
      case (state_q)
        ST_LEN_HI: if (accept) begin
          len_d[15:8] = rx.rx_data;
          state_d     = ST_LEN_LO;
        end
        ST_LEN_LO: if (accept) begin
          len_d = lenFull;
          if ((lenFull == 16'd0) || ({1'b0, lenFull} > DEPTH_LIM)) state_d = ST_ERR;
          else                                                     state_d = ST_DATA_HI;
        end
        ST_DATA_HI: if (accept) begin
          word_d  = {rx.rx_data, word_q[BYTE_W-1:0]};
          state_d = ST_DATA_LO;
        end
        ST_DATA_LO: if (accept) begin
          word_d  = {word_q[DATA_W-1:BYTE_W], rx.rx_data};
          state_d = ST_WRITE;
        end
        ST_WRITE: begin
          addr_d  = addr_q + 1'b1;
          count_d = countNext;
`ifdef PROG_LOADER_CKSUM_EN
          state_d = lastWord ? ST_CKSUM : ST_DATA_HI;
`else
          state_d = lastWord ? ST_DONE : ST_DATA_HI;
`endif
        end
`ifdef PROG_LOADER_CKSUM_EN
        ST_CKSUM: if (accept) begin
          state_d = (rx.rx_data == cksum_q) ? ST_DONE : ST_ERR;
        end
`endif
        default: state_d = state_q;
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      addr_q  <= '0;
      count_q <= '0;
      word_q  <= '0;
`ifdef PROG_LOADER_CKSUM_EN
      cksum_q <= CKSUM_SEED;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      word_q  <= word_d;
`ifdef PROG_LOADER_CKSUM_EN
      cksum_q <= cksum_d;
`endif
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader.
// Optional feature macro: PROG_LOADER_CKSUM_EN enables the checksum cases.
module tb_prog_loader;

  logic        CLK100MHZ;
  logic        rst;
  logic        start;
  logic        ld_sel;
  logic [7:0]  ld_addr;
  logic [15:0] ld_data;
  logic        ld_write;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        err;
  logic [8:0]  word_count;

  int          errCount;
  int          checkCount;
  int          writeCount;
  logic [7:0]  lastAddr;
  logic [15:0] memModel [256];
  logic [7:0]  streamQ [$];

  prog_loader_if rxIf ();

  prog_loader #(.ADDR_W(8), .DATA_W(16), .MEM_DEPTH(256)) dut (
    .CLK100MHZ (CLK100MHZ),
    .rst       (rst),
    .start     (start),
    .rx        (rxIf.slave),
    .ld_sel    (ld_sel),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .ld_write  (ld_write),
    .cpu_hold  (cpu_hold),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .word_count(word_count)
  );

  // Free-running 100 MHz clock.
  initial begin
    CLK100MHZ = 1'b0;
    forever #5 CLK100MHZ = ~CLK100MHZ;
  end

  // Capture every memory-bank write mid-cycle into the bench's memory image.
  always @(negedge CLK100MHZ) begin
    if (ld_write === 1'b1) begin
      memModel[ld_addr] = ld_data;
      lastAddr          = ld_addr;
      writeCount        = writeCount + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount = checkCount + 1;
    if (observed !== expected) begin
      errCount = errCount + 1;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic clearModel();
    for (int i = 0; i < 256; i++) memModel[i] = 16'hxxxx;
    writeCount = 0;
    lastAddr   = 8'h00;
  endtask

  task automatic pulseStart();
    @(posedge CLK100MHZ); #1;
    start = 1'b1;
    @(posedge CLK100MHZ); #1;
    start = 1'b0;
  endtask

  // Offers one byte after an idle gap and holds it until the loader takes it.
  task automatic sendByte(input logic [7:0] b, input int gap);
    bit taken;
    taken = 1'b0;
    repeat (gap) begin
      @(posedge CLK100MHZ); #1;
    end
    rxIf.rx_data  = b;
    rxIf.rx_valid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge CLK100MHZ);
      if (rxIf.rx_ready === 1'b1) begin
        @(posedge CLK100MHZ); #1;
        taken = 1'b1;
        break;
      end
    end
    rxIf.rx_valid = 1'b0;
    if (!taken) checkOutput("rxReadyTimeout", 32'd0, 32'd1);
  endtask

  // Sends the queued stream, then the XOR checksum byte when that feature is built in.
  task automatic applyStimulus(input int gap, input bit withCksum, input bit badCksum);
    logic [7:0] xorAcc;
    xorAcc = 8'h00;
    foreach (streamQ[i]) begin
      xorAcc = xorAcc ^ streamQ[i];
      sendByte(streamQ[i], gap);
    end
`ifdef PROG_LOADER_CKSUM_EN
    if (withCksum) sendByte(badCksum ? (xorAcc ^ 8'h01) : xorAcc, gap);
`else
    if (withCksum && badCksum) xorAcc = 8'h00;
`endif
  endtask

  task automatic waitFinish(input string tag);
    bit ended;
    ended = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(negedge CLK100MHZ);
      if (done === 1'b1 || err === 1'b1) begin
        ended = 1'b1;
        break;
      end
    end
    if (!ended) checkOutput({tag, "_finishTimeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    errCount      = 0;
    checkCount    = 0;
    rst           = 1'b1;
    start         = 1'b0;
    rxIf.rx_data  = 8'h00;
    rxIf.rx_valid = 1'b0;
    clearModel();
    repeat (3) @(posedge CLK100MHZ);
    #1 rst = 1'b0;

    // Reset state
    @(negedge CLK100MHZ);
    checkOutput("rst_rxReady",   32'(rxIf.rx_ready), 32'd0);
    checkOutput("rst_ldWrite",   32'(ld_write),      32'd0);
    checkOutput("rst_busy",      32'(busy),          32'd0);
    checkOutput("rst_done",      32'(done),          32'd0);
    checkOutput("rst_err",       32'(err),           32'd0);
    checkOutput("rst_ldSel",     32'(ld_sel),        32'd1);
    checkOutput("rst_cpuHold",   32'(cpu_hold),      32'd1);
    checkOutput("rst_ldAddr",    32'(ld_addr),       32'd0);
    checkOutput("rst_ldData",    32'(ld_data),       32'd0);
    checkOutput("rst_wordCount", 32'(word_count),    32'd0);

    // Nominal two-word load
    $display("[TB] nominal load");
    clearModel();
    pulseStart();
    checkOutput("nom_busyAfterStart", 32'(busy), 32'd1);
    streamQ = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    applyStimulus(0, 1'b1, 1'b0);
    waitFinish("nom");
    checkOutput("nom_mem0",      32'(memModel[0]), 32'h1234);
    checkOutput("nom_mem1",      32'(memModel[1]), 32'hABCD);
    checkOutput("nom_writes",    32'(writeCount),  32'd2);
    checkOutput("nom_done",      32'(done),        32'd1);
    checkOutput("nom_err",       32'(err),         32'd0);
    checkOutput("nom_cpuHold",   32'(cpu_hold),    32'd0);
    checkOutput("nom_ldSel",     32'(ld_sel),      32'd0);
    checkOutput("nom_busy",      32'(busy),        32'd0);
    checkOutput("nom_wordCount", 32'(word_count),  32'd2);

    // Same stream with the source stalling between bytes
    $display("[TB] stalled source");
    clearModel();
    pulseStart();
    applyStimulus(5, 1'b1, 1'b0);
    waitFinish("stall");
    checkOutput("stall_mem0",      32'(memModel[0]), 32'h1234);
    checkOutput("stall_mem1",      32'(memModel[1]), 32'hABCD);
    checkOutput("stall_writes",    32'(writeCount),  32'd2);
    checkOutput("stall_done",      32'(done),        32'd1);
    checkOutput("stall_wordCount", 32'(word_count),  32'd2);

    // Zero length is rejected
    $display("[TB] illegal lengths");
    clearModel();
    pulseStart();
    streamQ = '{8'h00, 8'h00};
    applyStimulus(0, 1'b0, 1'b0);
    waitFinish("len0");
    checkOutput("len0_err",     32'(err),        32'd1);
    checkOutput("len0_done",    32'(done),       32'd0);
    checkOutput("len0_cpuHold", 32'(cpu_hold),   32'd1);
    checkOutput("len0_ldSel",   32'(ld_sel),     32'd1);
    checkOutput("len0_writes",  32'(writeCount), 32'd0);

    // One past the memory depth is rejected
    pulseStart();
    checkOutput("len257_errCleared", 32'(err), 32'd0);
    streamQ = '{8'h01, 8'h01};
    applyStimulus(0, 1'b0, 1'b0);
    waitFinish("len257");
    checkOutput("len257_err",    32'(err),        32'd1);
    checkOutput("len257_writes", 32'(writeCount), 32'd0);

    // Full-depth image, each word holding its own address
    $display("[TB] full depth");
    clearModel();
    pulseStart();
    streamQ = '{8'h01, 8'h00};
    for (int i = 0; i < 256; i++) begin
      streamQ.push_back(8'h00);
      streamQ.push_back(8'(i));
    end
    applyStimulus(0, 1'b1, 1'b0);
    waitFinish("full");
    begin
      int badWords;
      badWords = 0;
      for (int i = 0; i < 256; i++) if (memModel[i] !== 16'(i)) badWords++;
      checkOutput("full_badWords", 32'(badWords), 32'd0);
    end
    checkOutput("full_writes",    32'(writeCount), 32'd256);
    checkOutput("full_lastAddr",  32'(lastAddr),   32'hFF);
    checkOutput("full_wordCount", 32'(word_count), 32'd256);
    checkOutput("full_done",      32'(done),       32'd1);

    // Reset after the first data byte, then a clean one-word load
    $display("[TB] reset mid-load");
    clearModel();
    pulseStart();
    streamQ = '{8'h00, 8'h02, 8'h55};
    applyStimulus(0, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge CLK100MHZ); #1;
    rst = 1'b0;
    @(negedge CLK100MHZ);
    checkOutput("midrst_busy",      32'(busy),          32'd0);
    checkOutput("midrst_cpuHold",   32'(cpu_hold),      32'd1);
    checkOutput("midrst_rxReady",   32'(rxIf.rx_ready), 32'd0);
    checkOutput("midrst_wordCount", 32'(word_count),    32'd0);
    checkOutput("midrst_writes",    32'(writeCount),    32'd0);
    pulseStart();
    streamQ = '{8'h00, 8'h01, 8'hBE, 8'hEF};
    applyStimulus(0, 1'b1, 1'b0);
    waitFinish("reload");
    checkOutput("reload_mem0",      32'(memModel[0]), 32'hBEEF);
    checkOutput("reload_writes",    32'(writeCount),  32'd1);
    checkOutput("reload_done",      32'(done),        32'd1);
    checkOutput("reload_wordCount", 32'(word_count),  32'd1);

    // Reset and start together: reset must win
    @(posedge CLK100MHZ); #1;
    rst   = 1'b1;
    start = 1'b1;
    @(posedge CLK100MHZ); #1;
    rst   = 1'b0;
    start = 1'b0;
    @(negedge CLK100MHZ);
    checkOutput("rstStart_busy",    32'(busy),     32'd0);
    checkOutput("rstStart_done",    32'(done),     32'd0);
    checkOutput("rstStart_cpuHold", 32'(cpu_hold), 32'd1);

`ifdef PROG_LOADER_CKSUM_EN
    // Checksum: XOR of 00 01 12 34 is 27
    $display("[TB] checksum");
    clearModel();
    pulseStart();
    streamQ = '{8'h00, 8'h01, 8'h12, 8'h34};
    applyStimulus(0, 1'b1, 1'b0);
    waitFinish("ckGood");
    checkOutput("ckGood_done", 32'(done),        32'd1);
    checkOutput("ckGood_mem0", 32'(memModel[0]), 32'h1234);
    pulseStart();
    applyStimulus(0, 1'b1, 1'b1);
    waitFinish("ckBad");
    checkOutput("ckBad_err",     32'(err),      32'd1);
    checkOutput("ckBad_cpuHold", 32'(cpu_hold), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
